// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, results
// held in output registers and flagged with a one-cycle done pulse.
module seq_restoring_divider #(
    parameter int unsigned DW = 8,
    parameter int unsigned VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          div_zero_q, div_zero_d;

    logic [VW:0]   shift_rem;
    logic [VW:0]   trial;
    logic          q_bit;

    // Next-state, datapath step and registered-output updates
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        // Stored remainder is always below the divisor, so it fits VW bits;
        // only the shifted trial value needs the extra bit.
        shift_rem = {rem_q, dvd_q[DW-1]};
        trial     = shift_rem - {1'b0, dvs_q};
        q_bit     = ~trial[VW];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvs_d = divisor;
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = '0;
                        div_zero_d  = 1'b1;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_RUN: begin
                rem_d = q_bit ? trial[VW-1:0] : shift_rem[VW-1:0];
                dvd_d = {dvd_q[DW-2:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    quotient_d  = dvd_d;
                    remainder_d = rem_d;
                    div_zero_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule
